ram_sp_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a request/ready access port, selectable read latency, selectable read-during-write mode and a built-in clear engine. It supersedes the fixed 256x16 CoreGen RAM wrapper. It is the scratch/data memory behind the datapath testers and needs no vendor IP: memory is inferred, and the clear engine makes the contents deterministic after reset.

---
 rtl/ram_sp_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ram_sp_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: single-port synchronous RAM behind a req/ready port.
// The RAM has a selectable read latency (1 or 2), a selectable read-during-write
// mode, and a clear engine that zero-fills the array one word per cycle.
// The array is inferred (no vendor IP). Reset never touches the array; only the
// clear engine zeroes it.
module ram_sp_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clear,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // The counter is one bit wider than the address, so DEPTH itself is representable.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic            RST_RDY = (CLR_ON_RST == 0) ? 1'b1 : 1'b0;
    localparam state_t          RST_ST  = (CLR_ON_RST == 0) ? IDLE : CLEAR;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W:0]   clr_cnt_r;
    logic [ADDR_W:0]   clr_cnt_nxt_s;
    logic              ready_r;
    logic              busy_r;

    logic              acc_s;
    logic              in_range_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] rd_data_s;

    logic [DATA_W-1:0] s1_data_r;
    logic              s1_valid_r;

    // The port accepts only from the registered ready flag, so acceptance never
    // depends combinationally on the request inputs themselves.
    assign acc_s      = req && ready_r;
    assign in_range_s = ({1'b0, addr} < DEPTH_C);

    // Next-state and clear-counter logic.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            CLEAR: begin
                if (clr_cnt_r == LAST_C) begin
                    state_nxt_s   = IDLE;
                    clr_cnt_nxt_s = '0;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + (ADDR_W+1)'(1);
                end
            end
            IDLE: begin
                if (clear) begin
                    state_nxt_s   = CLEAR;
                    clr_cnt_nxt_s = '0;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // State register; ready and busy are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RST_ST;
            clr_cnt_r <= '0;
            ready_r   <= RST_RDY;
            busy_r    <= ~RST_RDY;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            ready_r   <= (state_nxt_s == IDLE);
            busy_r    <= (state_nxt_s == CLEAR);
        end
    end

    // Select the array write: a zero-fill word while clearing, otherwise an
    // accepted in-range write. Out-of-range writes are dropped.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (state_r == CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_r[ADDR_W-1:0];
            wr_data_s = '0;
        end else if (acc_s && we && in_range_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr;
            wr_data_s = din;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Form the access result. Out-of-range addresses return zero. A write-first
    // access forwards din instead of the old word.
    always_comb begin
        rd_data_s = '0;
        if (!in_range_s) begin
            rd_data_s = '0;
        end else if (we && (WR_MODE != 0)) begin
            rd_data_s = din;
        end else begin
            rd_data_s = mem[addr];
        end
    end

    // Array write port. It has no reset, and writes are blocked while rst is high
    // so that reset never changes the contents.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    // First output stage: the registered memory result. Data holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= acc_s;
            if (acc_s) begin
                s1_data_r <= rd_data_s;
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign dout       = s1_data_r;
            assign dout_valid = s1_valid_r;
        end else begin : g_lat2
            logic [DATA_W-1:0] s2_data_r;
            logic              s2_valid_r;

            // Second output stage: adds one cycle of latency and holds the last result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_r <= 1'b0;
                    s2_data_r  <= '0;
                end else begin
                    s2_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        s2_data_r <= s1_data_r;
                    end
                end
            end

            assign dout       = s2_data_r;
            assign dout_valid = s2_valid_r;
        end
    endgenerate

    assign ready = ready_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Testbench for ram_sp_ctrl.
// Three configurations share one stimulus stream:
//   u0: default parameters (256 words, RD_LAT=1, read-first, clear after reset)
//   u1: RD_LAT=2, write-first, clear after reset
//   u2: 200 words, RD_LAT=1, write-first, no clear after reset
// A behavioural model for each instance holds a word array, a count of
// remaining clear cycles, and a schedule of results keyed by due cycle.
module tb_ram_sp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] din;
    logic        clear;

    logic        rdy [3];
    logic        bsy [3];
    logic        dv  [3];
    logic [15:0] dq  [3];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    ram_sp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din), .clear(clear),
        .ready(rdy[0]), .busy(bsy[0]), .dout(dq[0]), .dout_valid(dv[0]));

    ram_sp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .WR_MODE(1), .CLR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din), .clear(clear),
        .ready(rdy[1]), .busy(bsy[1]), .dout(dq[1]), .dout_valid(dv[1]));

    ram_sp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .WR_MODE(1), .CLR_ON_RST(0)) u2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din), .clear(clear),
        .ready(rdy[2]), .busy(bsy[2]), .dout(dq[2]), .dout_valid(dv[2]));

    // Model configuration, one entry per instance.
    int p_depth [3] = '{256, 256, 200};
    int p_lat   [3] = '{1, 2, 1};
    int p_wm    [3] = '{0, 1, 1};
    int p_clr   [3] = '{1, 1, 0};

    // Model state.
    logic [15:0] m_mem      [3][256];
    int          m_clr_left [3];
    logic        m_sv       [3][4];
    logic [15:0] m_sd       [3][4];
    logic [15:0] m_dout     [3];
    bit          m_on = 1'b0;
    int          cyc  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply one clock edge of behaviour to model instance i.
    task automatic model_edge(input int i);
        int          slot;
        logic [15:0] old_w;
        logic [15:0] res;
        slot = (cyc + p_lat[i] - 1) % 4;
        if (rst) begin
            m_clr_left[i] = (p_clr[i] != 0) ? p_depth[i] : 0;
            for (int s = 0; s < 4; s++) m_sv[i][s] = 1'b0;
            m_dout[i] = 16'h0000;
        end else if (m_clr_left[i] > 0) begin
            m_mem[i][p_depth[i] - m_clr_left[i]] = 16'h0000;
            m_clr_left[i] = m_clr_left[i] - 1;
        end else begin
            if (req) begin
                if (int'(addr) < p_depth[i]) begin
                    old_w = m_mem[i][addr];
                    if (we) m_mem[i][addr] = din;
                    res = (we && p_wm[i] != 0) ? din : old_w;
                end else begin
                    res = 16'h0000;
                end
                m_sv[i][slot] = 1'b1;
                m_sd[i][slot] = res;
            end
            if (clear) m_clr_left[i] = p_depth[i];
        end
    endtask

    // Advance the models on every active edge.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) model_edge(i);
        if (rst) m_on = 1'b1;
    end

    // Compare each DUT against its model midway between edges.
    always @(negedge clk) begin
        if (m_on) begin
            for (int i = 0; i < 3; i++) begin
                automatic int   slot = cyc % 4;
                automatic logic ev   = m_sv[i][slot];
                if (ev) m_dout[i] = m_sd[i][slot];
                m_sv[i][slot] = 1'b0;
                check_val($sformatf("u%0d.ready", i), 32'(rdy[i]), 32'(m_clr_left[i] == 0));
                check_val($sformatf("u%0d.busy", i),  32'(bsy[i]), 32'(m_clr_left[i] != 0));
                check_val($sformatf("u%0d.dout_valid", i), 32'(dv[i]), 32'(ev));
                check_val($sformatf("u%0d.dout", i), 32'(dq[i]), 32'(m_dout[i]));
            end
        end
    end

    task automatic step(input logic r, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic c);
        req   = r;
        we    = w;
        addr  = a;
        din   = d;
        clear = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] a;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; din = 16'h0000; clear = 1'b0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        // u2 is ready at once, while u0 and u1 clear and ignore these requests.
        step(1'b1, 1'b1, 8'd210, 16'h5555, 1'b0);
        step(1'b1, 1'b0, 8'd210, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 8'd199, 16'hABCD, 1'b0);
        step(1'b1, 1'b0, 8'd199, 16'h0000, 1'b0);
        idle(2);
        // Clear u2 so that its contents are defined.
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        idle(260);

        // After the clear, reads return zero.
        step(1'b1, 1'b0, 8'd0,   16'h0000, 1'b0);
        step(1'b1, 1'b0, 8'd127, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 8'd255, 16'h0000, 1'b0);
        idle(3);

        // Write/read, then back-to-back reads.
        step(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 8'h11, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 8'h11, 16'h0000, 1'b0);
        idle(4);

        // Read-during-write.
        step(1'b1, 1'b1, 8'h20, 16'h1111, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 8'h20, 16'h2222, 1'b0);
        step(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
        idle(4);

        // A clear issued in the same cycle as a write.
        step(1'b1, 1'b1, 8'd5, 16'hAAAA, 1'b1);
        idle(260);
        step(1'b1, 1'b0, 8'd5, 16'h0000, 1'b0);
        idle(4);

        // Randomised traffic with occasional clears.
        for (int k = 0; k < 700; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 220)) : 8'($urandom_range(0, 31));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                 16'($urandom), 1'($urandom_range(0, 199) == 0));
        end
        idle(262);

        // Reset at clear cycle 100 restarts a full-length clear.
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        idle(100);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        n = 0;
        while (bsy[0] && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_val("busy_len_after_rst", 32'(n), 32'd256);
        step(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
